// File: rtl/alu_seq.sv
// alu_seq: clocked ALU with start/busy/done handshake; shifts and popcount iterate one step per cycle.
// Optional saturating add/sub (opcodes 11/12) enabled by defining ALU_SEQ_SAT_EN.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             optype,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0] reg_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             z,
  output logic             c,
  output logic             n,
  output logic             v
);

  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_SHL  = 4'd4;
  localparam logic [3:0] OP_SHR  = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_XOR  = 4'd8;
  localparam logic [3:0] OP_POP  = 4'd9;
  localparam logic [3:0] OP_CMP  = 4'd10;
`ifdef ALU_SEQ_SAT_EN
  localparam logic [3:0] OP_SADD = 4'd11;
  localparam logic [3:0] OP_SSUB = 4'd12;
`endif

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_WID = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_POP = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] VAL_WID = WIDTH'(WIDTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [3:0]       lop;
  logic [WIDTH-1:0] work, work_nxt;
  logic [WIDTH-1:0] opnd, opnd_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic [WIDTH:0]   sum, diff;
  logic [CNT_W-1:0] k;
  logic [WIDTH-1:0] res;
  logic             fin, set_out, set_zn, set_cv;
  logic             rz, rc, rn, rv;

  assign sum  = {1'b0, acc_in} + {1'b0, reg_in};
  assign diff = {1'b0, acc_in} - {1'b0, reg_in};
  assign k    = (reg_in >= VAL_WID) ? CNT_WID : reg_in[CNT_W-1:0];
  assign busy = (state == RUN);

  always_comb begin
    state_nxt = state;
    work_nxt  = work;
    opnd_nxt  = opnd;
    cnt_nxt   = cnt;
    res       = out;
    fin       = 1'b0;
    set_out   = 1'b0;
    set_zn    = 1'b0;
    set_cv    = 1'b0;
    rz        = z;
    rc        = c;
    rn        = n;
    rv        = v;
    case (state)
      IDLE: begin
        if (start) begin
          fin = 1'b1;
          if (!optype) begin
            case (op)
              OP_ADD: begin
                res = sum[WIDTH-1:0]; rc = sum[WIDTH]; set_out = 1'b1; set_cv = 1'b1;
                rv = (acc_in[WIDTH-1] == reg_in[WIDTH-1]) && (sum[WIDTH-1] != acc_in[WIDTH-1]);
              end
              OP_SUB: begin
                res = diff[WIDTH-1:0]; rc = diff[WIDTH]; set_out = 1'b1; set_cv = 1'b1;
                rv = (acc_in[WIDTH-1] != reg_in[WIDTH-1]) && (diff[WIDTH-1] != acc_in[WIDTH-1]);
              end
              OP_SHL, OP_SHR: begin
                // First bit position is shifted on the accept edge; RUN covers the remaining k-1.
                if (k <= CNT_ONE) begin
                  set_out = 1'b1;
                  if (k == '0)          res = acc_in;
                  else if (op == OP_SHL) res = acc_in << 1;
                  else                   res = acc_in >> 1;
                end else begin
                  fin       = 1'b0;
                  state_nxt = RUN;
                  work_nxt  = (op == OP_SHL) ? (acc_in << 1) : (acc_in >> 1);
                  cnt_nxt   = k - CNT_ONE;
                end
              end
              OP_AND: begin res = acc_in & reg_in; set_out = 1'b1; end
              OP_OR:  begin res = acc_in | reg_in; set_out = 1'b1; end
              OP_XOR: begin res = acc_in ^ reg_in; set_out = 1'b1; end
              OP_POP: begin
                fin       = 1'b0;
                state_nxt = RUN;
                work_nxt  = WIDTH'(reg_in[0]);
                opnd_nxt  = reg_in >> 1;
                cnt_nxt   = CNT_POP;
              end
              OP_CMP: begin
                set_zn = 1'b1;
                rz     = (acc_in == reg_in);
                rn     = diff[WIDTH];
              end
`ifdef ALU_SEQ_SAT_EN
              OP_SADD: begin
                res = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
                rc = sum[WIDTH]; rv = 1'b0; set_out = 1'b1; set_cv = 1'b1;
              end
              OP_SSUB: begin
                res = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
                rc = diff[WIDTH]; rv = 1'b0; set_out = 1'b1; set_cv = 1'b1;
              end
`endif
              default: ;
            endcase
          end
        end
      end
      RUN: begin
        case (lop)
          OP_SHL:  work_nxt = work << 1;
          OP_SHR:  work_nxt = work >> 1;
          default: begin
            work_nxt = work + WIDTH'(opnd[0]);
            opnd_nxt = opnd >> 1;
          end
        endcase
        cnt_nxt = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          state_nxt = IDLE;
          fin       = 1'b1;
          set_out   = 1'b1;
          res       = work_nxt;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Every op that writes out also refreshes z/n from it; cmp sets z/n directly.
    if (set_out) begin
      rz = ~|res;
      rn = res[WIDTH-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lop  <= '0;
      work <= '0;
      opnd <= '0;
      cnt  <= '0;
      done <= 1'b0;
      out  <= '0;
      z    <= 1'b0;
      c    <= 1'b0;
      n    <= 1'b0;
      v    <= 1'b0;
    end else begin
      if (state == IDLE && start) lop <= op;
      work <= work_nxt;
      opnd <= opnd_nxt;
      cnt  <= cnt_nxt;
      done <= fin;
      if (set_out) out <= res;
      if (set_out || set_zn) begin
        z <= rz;
        n <= rn;
      end
      if (set_cv) begin
        c <= rc;
        v <= rv;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq (WIDTH=8); obs packs {done,busy,out,z,c,n,v}.
module tb_alu_seq;
  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       optype;
  logic [3:0] op;
  logic [7:0] acc_in;
  logic [7:0] reg_in;
  logic       busy, done, z, c, n, v;
  logic [7:0] out;

  int vecs = 0;
  int errs = 0;

  wire [13:0] obs = {done, busy, out, z, c, n, v};

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .optype(optype), .op(op),
    .acc_in(acc_in), .reg_in(reg_in), .busy(busy), .done(done), .out(out),
    .z(z), .c(c), .n(n), .v(v)
  );

  always #5 clk = ~clk;

  task step;
    @(posedge clk);
    #1;
  endtask

  task drive(input logic ot, input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
    start  = 1'b1;
    optype = ot;
    op     = o;
    acc_in = a;
    reg_in = b;
  endtask

  task test_reset;
    reset = 1'b1; start = 1'b0; optype = 1'b0; op = 4'd0; acc_in = 8'h00; reg_in = 8'h00;
    step; step;
    vecs++;
    if (obs !== {1'b0, 1'b0, 8'h00, 4'b0000}) begin
      errs++; $display("FAIL reset_state: got %h want %h", obs, {1'b0, 1'b0, 8'h00, 4'b0000});
    end
    drive(1'b0, 4'd2, 8'hF0, 8'h20);
    step;
    vecs++;
    if (obs !== {1'b0, 1'b0, 8'h00, 4'b0000}) begin
      errs++; $display("FAIL start_in_reset: got %h want %h", obs, {1'b0, 1'b0, 8'h00, 4'b0000});
    end
    start = 1'b0; reset = 1'b0;
    step;
  endtask

  task test_add;
    drive(1'b0, 4'd2, 8'hF0, 8'h20);
    step; start = 1'b0;
    vecs++;
    if (obs !== {1'b1, 1'b0, 8'h10, 4'b0100}) begin
      errs++; $display("FAIL add_f0_20: got %h want %h", obs, {1'b1, 1'b0, 8'h10, 4'b0100});
    end
    step;
    vecs++;
    if (obs !== {1'b0, 1'b0, 8'h10, 4'b0100}) begin
      errs++; $display("FAIL add_hold: got %h want %h", obs, {1'b0, 1'b0, 8'h10, 4'b0100});
    end
  endtask

  task test_sub;
    drive(1'b0, 4'd3, 8'h80, 8'h01);
    step; start = 1'b0;
    vecs++;
    if (obs !== {1'b1, 1'b0, 8'h7F, 4'b0001}) begin
      errs++; $display("FAIL sub_80_01: got %h want %h", obs, {1'b1, 1'b0, 8'h7F, 4'b0001});
    end
  endtask

  task test_logic;
    drive(1'b0, 4'd6, 8'hF0, 8'h3C);
    step; start = 1'b0;
    vecs++;
    if (obs !== {1'b1, 1'b0, 8'h30, 4'b0001}) begin
      errs++; $display("FAIL and: got %h want %h", obs, {1'b1, 1'b0, 8'h30, 4'b0001});
    end
    drive(1'b0, 4'd7, 8'hF0, 8'h0F);
    step; start = 1'b0;
    vecs++;
    if (obs !== {1'b1, 1'b0, 8'hFF, 4'b0011}) begin
      errs++; $display("FAIL or: got %h want %h", obs, {1'b1, 1'b0, 8'hFF, 4'b0011});
    end
    drive(1'b0, 4'd8, 8'hAA, 8'hAA);
    step; start = 1'b0;
    vecs++;
    if (obs !== {1'b1, 1'b0, 8'h00, 4'b1001}) begin
      errs++; $display("FAIL xor: got %h want %h", obs, {1'b1, 1'b0, 8'h00, 4'b1001});
    end
  endtask

  task test_shift;
    int lat;
    drive(1'b0, 4'd4, 8'h01, 8'd3);
    step; start = 1'b0;
    vecs++;
    if ({done, busy} !== 2'b01) begin
      errs++; $display("FAIL shl3_t1: got done/busy %b want 01", {done, busy});
    end
    step;
    vecs++;
    if ({done, busy} !== 2'b01) begin
      errs++; $display("FAIL shl3_t2: got done/busy %b want 01", {done, busy});
    end
    step;
    vecs++;
    if (obs !== {1'b1, 1'b0, 8'h08, 4'b0001}) begin
      errs++; $display("FAIL shl3_done: got %h want %h", obs, {1'b1, 1'b0, 8'h08, 4'b0001});
    end
    drive(1'b0, 4'd5, 8'hFF, 8'd9);
    step; start = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      step; lat++;
    end
    vecs++;
    if (lat !== 8) begin
      errs++; $display("FAIL shr9_latency: got %0d want 8", lat);
    end
    vecs++;
    if (obs !== {1'b1, 1'b0, 8'h00, 4'b1001}) begin
      errs++; $display("FAIL shr9_result: got %h want %h", obs, {1'b1, 1'b0, 8'h00, 4'b1001});
    end
    drive(1'b0, 4'd4, 8'hA5, 8'd0);
    step; start = 1'b0;
    vecs++;
    if (obs !== {1'b1, 1'b0, 8'hA5, 4'b0011}) begin
      errs++; $display("FAIL shl0: got %h want %h", obs, {1'b1, 1'b0, 8'hA5, 4'b0011});
    end
    drive(1'b0, 4'd4, 8'h81, 8'd1);
    step; start = 1'b0;
    vecs++;
    if (obs !== {1'b1, 1'b0, 8'h02, 4'b0001}) begin
      errs++; $display("FAIL shl1: got %h want %h", obs, {1'b1, 1'b0, 8'h02, 4'b0001});
    end
    drive(1'b0, 4'd5, 8'h80, 8'd2);
    step; start = 1'b0;
    vecs++;
    if ({done, busy} !== 2'b01) begin
      errs++; $display("FAIL shr2_t1: got done/busy %b want 01", {done, busy});
    end
    step;
    vecs++;
    if (obs !== {1'b1, 1'b0, 8'h20, 4'b0001}) begin
      errs++; $display("FAIL shr2_done: got %h want %h", obs, {1'b1, 1'b0, 8'h20, 4'b0001});
    end
  endtask

  task test_popcnt_back_to_back;
    drive(1'b0, 4'd9, 8'h00, 8'hB7);
    step; start = 1'b0;
    vecs++;
    if ({done, busy} !== 2'b01) begin
      errs++; $display("FAIL pop_t1: got done/busy %b want 01", {done, busy});
    end
    step; step; step;
    drive(1'b0, 4'd2, 8'h03, 8'h04);
    step; start = 1'b0;
    vecs++;
    if ({done, busy} !== 2'b01) begin
      errs++; $display("FAIL pop_busy_start_ignored: got done/busy %b want 01", {done, busy});
    end
    step; step;
    vecs++;
    if ({done, busy} !== 2'b01) begin
      errs++; $display("FAIL pop_t7: got done/busy %b want 01", {done, busy});
    end
    step;
    vecs++;
    if (obs !== {1'b1, 1'b0, 8'h06, 4'b0001}) begin
      errs++; $display("FAIL pop_done_t8: got %h want %h", obs, {1'b1, 1'b0, 8'h06, 4'b0001});
    end
    drive(1'b0, 4'd2, 8'h01, 8'h01);
    step; start = 1'b0;
    vecs++;
    if (obs !== {1'b1, 1'b0, 8'h02, 4'b0000}) begin
      errs++; $display("FAIL back_to_back_add: got %h want %h", obs, {1'b1, 1'b0, 8'h02, 4'b0000});
    end
    step;
    vecs++;
    if (obs !== {1'b0, 1'b0, 8'h02, 4'b0000}) begin
      errs++; $display("FAIL no_queued_op: got %h want %h", obs, {1'b0, 1'b0, 8'h02, 4'b0000});
    end
  endtask

  task test_cmp;
    drive(1'b0, 4'd2, 8'hFF, 8'h02);
    step; start = 1'b0;
    vecs++;
    if (obs !== {1'b1, 1'b0, 8'h01, 4'b0100}) begin
      errs++; $display("FAIL add_ff_02: got %h want %h", obs, {1'b1, 1'b0, 8'h01, 4'b0100});
    end
    drive(1'b0, 4'd10, 8'h05, 8'h09);
    step; start = 1'b0;
    vecs++;
    if (obs !== {1'b1, 1'b0, 8'h01, 4'b0110}) begin
      errs++; $display("FAIL cmp_5_9: got %h want %h", obs, {1'b1, 1'b0, 8'h01, 4'b0110});
    end
    drive(1'b0, 4'd10, 8'h09, 8'h09);
    step; start = 1'b0;
    vecs++;
    if (obs !== {1'b1, 1'b0, 8'h01, 4'b1100}) begin
      errs++; $display("FAIL cmp_9_9: got %h want %h", obs, {1'b1, 1'b0, 8'h01, 4'b1100});
    end
  endtask

  task test_undef_and_sat;
    drive(1'b1, 4'd2, 8'hF0, 8'h20);
    step; start = 1'b0;
    vecs++;
    if (obs !== {1'b1, 1'b0, 8'h01, 4'b1100}) begin
      errs++; $display("FAIL optype1_noop: got %h want %h", obs, {1'b1, 1'b0, 8'h01, 4'b1100});
    end
    drive(1'b0, 4'd15, 8'hF0, 8'h20);
    step; start = 1'b0;
    vecs++;
    if (obs !== {1'b1, 1'b0, 8'h01, 4'b1100}) begin
      errs++; $display("FAIL undef_op15: got %h want %h", obs, {1'b1, 1'b0, 8'h01, 4'b1100});
    end
    drive(1'b0, 4'd11, 8'hF0, 8'h20);
    step; start = 1'b0;
    vecs++;
`ifdef ALU_SEQ_SAT_EN
    if (obs !== {1'b1, 1'b0, 8'hFF, 4'b0110}) begin
      errs++; $display("FAIL sat_add: got %h want %h", obs, {1'b1, 1'b0, 8'hFF, 4'b0110});
    end
`else
    if (obs !== {1'b1, 1'b0, 8'h01, 4'b1100}) begin
      errs++; $display("FAIL op11_undef: got %h want %h", obs, {1'b1, 1'b0, 8'h01, 4'b1100});
    end
`endif
  endtask

  task test_reset_mid_op;
    int seen;
    drive(1'b0, 4'd9, 8'h00, 8'hFF);
    step; start = 1'b0;
    step; step;
    reset = 1'b1;
    #1;
    vecs++;
    if (obs !== {1'b0, 1'b0, 8'h00, 4'b0000}) begin
      errs++; $display("FAIL reset_mid_popcnt: got %h want %h", obs, {1'b0, 1'b0, 8'h00, 4'b0000});
    end
    step;
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step;
      if (done || busy) seen++;
    end
    vecs++;
    if (seen !== 0) begin
      errs++; $display("FAIL aborted_no_done: got %0d active cycles want 0", seen);
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_logic;
    test_shift;
    test_popcnt_back_to_back;
    test_cmp;
    test_undef_and_sat;
    test_reset_mid_op;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, clocked successor to the datapath ALU; drop-in for the accumulator datapath.
- Same opcode map and flag set, generalised to WIDTH bits.
- Adds a start/busy/done handshake and registered result/flag outputs.
- Shifts and popcount run as multi-cycle iterative operations.

Parameters:
- WIDTH, 8, operand/result width in bits (>=4).
- CNT_W, $clog2(WIDTH+1), width of the internal iteration counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only while busy=0.
- optype  input  1  0 = ALU op; 1 = non-ALU (no-op here).
- op  input  4  opcode (2 add, 3 sub, 4 shl, 5 shr, 6 and, 7 or, 8 xor, 9 popcnt, 10 cmp).
- acc_in  input  WIDTH  accumulator operand.
- reg_in  input  WIDTH  register operand / shift amount.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse: out/flags updated this cycle.
- out  output  WIDTH  registered result.
- z, c, n, v  output  1 each  registered zero/carry/negative/overflow flags.

Behaviour:
- Reset (async, any state, including mid-operation): FSM=IDLE; out=0; z=c=n=v=0; busy=0; done=0. Any in-flight operation is aborted and no done is issued.
- FSM states: IDLE, RUN.
- Accept: start=1 in IDLE in cycle T latches optype, op, acc_in, reg_in. start while busy=1 is ignored and not queued.
- Latency L: done=1 in cycle T+L with out/flags already updated. busy=1 in cycles T+1..T+L-1. busy=0 in the done cycle, so a start in the done cycle is accepted (back-to-back).
- L values:
  - add/sub/logic/cmp/no-op: L=1 (IDLE->IDLE, no RUN).
  - shl/shr: k=min(reg_in,WIDTH); L=max(k,1); one bit position per RUN cycle.
  - popcnt: L=WIDTH; one bit of reg_in examined per cycle, LSB first.
- Arithmetic rules:
  - add: {c,out} = acc+reg (WIDTH+1 bits); v = signed overflow.
  - sub: out = acc-reg mod 2^WIDTH; c = 1 iff acc<reg unsigned (borrow); v = signed overflow.
  - shl/shr: logical, zero fill. reg_in=0 gives out=acc_in, L=1. reg_in>=WIDTH gives out=0.
  - and/or/xor: bitwise.
  - popcnt: out = number of ones in reg_in (0..WIDTH), zero-extended.
- Flags:
  - add/sub: z,n,c,v all updated from the result (n = out[WIDTH-1]).
  - shift/logic/popcnt: z,n updated; c,v held.
  - cmp: out held. z=1 iff acc==reg. n=1 iff acc<reg unsigned. c,v held.
- optype=1 or undefined op: done pulses at L=1; out and flags held.
- Outputs hold their value between operations.

Optional Feature:
- Macro ALU_SEQ_SAT_EN.
- Defined: opcode 11 = saturating unsigned add (clamps to 2^WIDTH-1, c=1 when clamped); opcode 12 = saturating unsigned sub (clamps to 0, c=1 when clamped). Both L=1; z,n updated; v=0.
- Undefined: opcodes 11/12 behave as undefined ops (done at L=1, out and flags held).

Test Plan:
- Reset then start add acc=8'hF0 reg=8'h20 -> done at T+1; out=8'h10, c=1, z=0, n=0, v=0.
- sub acc=8'h80 reg=8'h01 -> out=8'h7F, c=0, v=1, n=0.
- shl acc=8'h01 reg=3 -> busy high T+1..T+2, done at T+3, out=8'h08. Then shr reg=9 -> done at T+8, out=0, z=1.
- popcnt reg=8'hB7 -> done exactly at T+8, out=6. A start at T+4 is ignored; a start in the done cycle is accepted.
- cmp acc=5 reg=9 -> out unchanged, z=0, n=1. cmp acc=9 reg=9 -> z=1, n=0; c,v unchanged both times.
- Assert reset at T+3 of a popcnt -> all outputs 0 immediately, no done pulse. With ALU_SEQ_SAT_EN: op 11, acc=8'hF0, reg=8'h20 -> out=8'hFF, c=1.
